if_prefetch: RTL and testbench

Instruction-fetch front end that replaces the bare fetch stage ahead of the IF/ID pipeline register. It issues word-addressed requests to instruction memory over a valid/ready request channel and an in-order response channel. Fetched words are buffered with their PCs in a small prefetch queue, and the queue head is presented to IF/ID with a valid flag. Branch redirects from the MEM-stage decision flush the queue and discard in-flight responses. A HALT decoded in ID freezes fetch until reset.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/pf_fifo.sv | 55 +++++
 rtl/if_prefetch.sv | 118 +++++++++++
 tb/tb_if_prefetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default reset PC and fetch FSM states.
package cpu_pkg;

  localparam int XLEN = 16;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  // Fetch front-end state: RUN fetches normally, HALT is frozen until reset.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pf_fifo.sv
// Generic synchronous FIFO with synchronous clear; head word is always visible.
module pf_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end with a small prefetch queue, branch flush and halt.
//
// Handshake: a request transfers on any rising clk where imem_req_valid and
// imem_req_ready are both high; imem_req_valid/addr never depend on
// imem_req_ready. Responses are in order and carry no ready: each one pulses
// imem_rsp_valid for exactly one cycle and must be consumed. Toward IF/ID,
// the head instruction transfers when if_valid is high and stall_if is low.
module if_prefetch
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            stall_if,
  input  logic            flush_if,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

  fetch_state_t      state;
  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     q_count;
  logic              q_full, q_empty;
  logic              tag_full, tag_empty;
  logic [XLEN-1:0]   tag_head;
  logic [2*XLEN-1:0] q_head;
  logic [CW:0]       credit_used;
  logic              running, flush_eff, accept, rsp_ok, rsp_drop, q_push, q_pop;

  // The tag FIFO holds exactly one entry per accepted, unanswered request,
  // so its occupancy is the outstanding-request count.
  assign running     = (state == RUN);
  assign flush_eff   = running & flush_if;
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding};

  assign imem_req_valid = !rst & running & !flush_if & !halt & !tag_full & !q_full
                          & (credit_used < DEPTH_LIM);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a protocol violation and ignored.
  assign rsp_ok   = imem_rsp_valid & !tag_empty;
  assign rsp_drop = (discard != '0) | flush_eff;
  assign q_push   = rsp_ok & !rsp_drop;

  assign if_valid = running & !q_empty;
  assign q_pop    = if_valid & !stall_if & !flush_eff;
  assign if_pc    = q_head[2*XLEN-1:XLEN];
  assign if_instr = q_head[XLEN-1:0];

  // Fetch state machine: halt freezes fetch until reset, a same-cycle flush wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else if (running && halt && !flush_if) begin
      state  <= HALT;
      halted <= 1'b1;
    end
  end

  // Fetch PC and the count of in-flight responses to throw away after a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (flush_eff) begin
      fetch_pc <= redirect_pc;
      discard  <= outstanding - CW'(rsp_ok);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 16'd1;
      if (rsp_ok && discard != '0) discard <= discard - 1'b1;
    end
  end

  pf_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_ok),
    .head      (tag_head),
    .count     (outstanding),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  pf_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_out_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_eff),
    .push      (q_push),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a fixed-latency in-order memory model.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        stall_if;
  logic        flush_if;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard of PCs expected at the IF/ID boundary
  logic [15:0] exp_q[$];

  // memory model state
  int          mem_lat = 1;
  int          cyc = 0;
  logic        acc_seen = 1'b0;
  logic [15:0] acc_addr = '0;
  logic [15:0] pend_addr[$];
  int          pend_due[$];

  if_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_if       (stall_if),
    .flush_if       (flush_if),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // memory: note accepted requests mid-cycle, answer mem_lat cycles later
  initial forever begin
    @(negedge clk);
    acc_seen = !rst && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
  end

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (acc_seen) begin
          pend_addr.push_back(acc_addr);
          pend_due.push_back(cyc + mem_lat - 1);
        end
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = pend_addr[0] ^ 16'hA5A5;
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst         = 1'b1;
    stall_if    = 1'b0;
    flush_if    = 1'b0;
    halt        = 1'b0;
    redirect_pc = '0;
    mem_lat     = lat;
    tick();
    tick();
    #2;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr",  imem_req_addr, 16'h0000);
    check("rst_if_valid",  if_valid, 0);
    check("rst_if_pc",     if_pc, 16'h0000);
    check("rst_if_instr",  if_instr, 16'h0000);
    check("rst_halted",    halted, 0);
    tick();
    #1;
    rst = 1'b0;
    #2;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr",  imem_req_addr, 16'h0000);
    check("first_if_valid",  if_valid, 0);
    tick();
    #2;
    check("no_bypass_if_valid", if_valid, 0);
  endtask

  // expect n consecutive PCs from start within budget cycles, stall low
  task automatic expect_stream(input logic [15:0] start, input int n, input int budget);
    logic [15:0] pc;
    logic [15:0] exp_pc;
    int got;
    int spent;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      pc = pc + 16'd1;
    end
    got   = 0;
    spent = 0;
    while (got < n && spent < budget) begin
      tick();
      stall_if = 1'b0;
      flush_if = 1'b0;
      halt     = 1'b0;
      #2;
      spent++;
      if (if_valid) begin
        exp_pc = exp_q.pop_front();
        check("stream_pc",    if_pc, exp_pc);
        check("stream_instr", if_instr, exp_pc ^ 16'hA5A5);
        got++;
      end
    end
    check("stream_count", got, n);
    exp_q.delete();
  endtask

  initial begin
    imem_req_ready = 1'b1;

    // reset release and back-to-back fetch from PC 0
    do_reset(1);
    expect_stream(16'h0000, 8, 8);

    // stall for 10 cycles: requests stop once the queue plus in-flight reach 4
    for (int i = 0; i < 10; i++) begin
      tick();
      stall_if = 1'b1;
      #2;
      check("stall_valid", if_valid, 1);
      check("stall_head",  if_pc, 16'h0008);
      if (i >= 2) check("stall_no_req", imem_req_valid, 0);
    end
    expect_stream(16'h0008, 12, 16);

    // flush and halt together: flush wins
    tick();
    flush_if    = 1'b1;
    halt        = 1'b1;
    redirect_pc = 16'h0100;
    #2;
    check("flush_blocks_req", imem_req_valid, 0);
    tick();
    flush_if = 1'b0;
    halt     = 1'b0;
    #2;
    check("fh_halted",    halted, 0);
    check("fh_if_valid",  if_valid, 0);
    check("fh_req_valid", imem_req_valid, 1);
    check("fh_req_addr",  imem_req_addr, 16'h0100);
    expect_stream(16'h0100, 4, 8);

    // wrap of the fetch PC
    tick();
    flush_if    = 1'b1;
    redirect_pc = 16'hFFFE;
    #2;
    tick();
    flush_if = 1'b0;
    #2;
    check("wrap_req_addr", imem_req_addr, 16'hFFFE);
    expect_stream(16'hFFFE, 3, 8);

    // halt alone freezes fetch; a flush while halted is ignored
    tick();
    halt = 1'b1;
    #2;
    tick();
    halt = 1'b0;
    #2;
    check("halt_halted",    halted, 1);
    check("halt_if_valid",  if_valid, 0);
    check("halt_req_valid", imem_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      flush_if    = (i == 1);
      redirect_pc = 16'h0200;
      #2;
      check("halt_hold_halted", halted, 1);
      check("halt_hold_valid",  if_valid, 0);
      check("halt_hold_req",    imem_req_valid, 0);
    end
    flush_if = 1'b0;

    // latency 3 with three requests in flight, then flush to 0x0040
    do_reset(3);
    tick();
    tick();
    flush_if    = 1'b1;
    redirect_pc = 16'h0040;
    #2;
    check("lat3_flush_req", imem_req_valid, 0);
    tick();
    flush_if = 1'b0;
    #2;
    check("lat3_if_valid",  if_valid, 0);
    check("lat3_req_valid", imem_req_valid, 1);
    check("lat3_req_addr",  imem_req_addr, 16'h0040);
    expect_stream(16'h0040, 4, 20);

    // fill the queue under stall, then reset asynchronously mid-cycle
    for (int i = 0; i < 8; i++) begin
      tick();
      stall_if = 1'b1;
      #2;
    end
    check("pre_rst_valid", if_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_req_valid", imem_req_valid, 0);
    check("async_rst_req_addr",  imem_req_addr, 16'h0000);
    check("async_rst_if_valid",  if_valid, 0);
    check("async_rst_if_pc",     if_pc, 16'h0000);
    check("async_rst_if_instr",  if_instr, 16'h0000);
    check("async_rst_halted",    halted, 0);
    do_reset(1);
    expect_stream(16'h0000, 4, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
